// File: rtl/mbisr_repair_map.sv
// mbisr_repair_map: allocates spare words to MBIST-reported failing
// addresses, then translates functional lookups to array or spare slot.
//
// Ports:
//   clk, rst_n (sync, active-low), clr (sync clear of map and status)
//   fail_valid/fail_addr/fail_ready : fail-report intake from MBIST
//   lock                            : MBIST done pulse, freezes the map
//   req_valid/req_addr              : functional lookup request
//   map_valid/map_spare/map_idx     : registered lookup result
//   used_cnt, locked, overflow      : repair status
//   hit_cnt                         : remapped-lookup counter
//
// Optional feature macro: MBISR_HIT_CNT_EN
//   defined   -> hit_cnt counts cycles with map_valid & map_spare,
//                saturating at 255
//   undefined -> hit_cnt tied to 0, no counter flops
module mbisr_repair_map #(
    parameter int ADDR_W = 4,
    parameter int SPARES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              fail_valid,
    input  logic [ADDR_W-1:0] fail_addr,
    output logic              fail_ready,
    input  logic              lock,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              map_valid,
    output logic              map_spare,
    output logic [1:0]        map_idx,
    output logic [2:0]        used_cnt,
    output logic              locked,
    output logic              overflow,
    output logic [7:0]        hit_cnt
);

    typedef enum logic [1:0] {
        S_LOG  = 2'd0,
        S_OVF  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t            state;
    logic [SPARES-1:0] ent_v;
    logic [ADDR_W-1:0] ent_tag [SPARES];

    logic       fail_hit;
    logic       req_hit;
    logic [1:0] req_idx;
    logic       is_new;
    logic       full;

    // Descending scan so the lowest matching entry wins.
    always_comb begin
        fail_hit = 1'b0;
        req_hit  = 1'b0;
        req_idx  = 2'd0;
        for (int i = SPARES - 1; i >= 0; i--) begin
            if (ent_v[i] && ent_tag[i] == fail_addr) begin
                fail_hit = 1'b1;
            end
            if (ent_v[i] && ent_tag[i] == req_addr) begin
                req_hit = 1'b1;
                req_idx = 2'(i);
            end
        end
    end

    assign is_new     = fail_valid && !fail_hit;
    assign full       = (used_cnt == 3'(SPARES));
    assign fail_ready = (state != S_LOCK);
    assign locked     = (state == S_LOCK);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= S_LOG;
            ent_v     <= '0;
            used_cnt  <= 3'd0;
            overflow  <= 1'b0;
            map_valid <= 1'b0;
            map_spare <= 1'b0;
            map_idx   <= 2'd0;
            for (int i = 0; i < SPARES; i++) begin
                ent_tag[i] <= '0;
            end
        end else begin
            // Lookup sees the map as it was before this edge.
            map_valid <= req_valid;
            if (req_valid) begin
                map_spare <= req_hit;
                map_idx   <= req_hit ? req_idx : 2'd0;
            end

            unique case (state)
                S_LOG: begin
                    if (is_new && !full) begin
                        for (int i = 0; i < SPARES; i++) begin
                            if (3'(i) == used_cnt) begin
                                ent_v[i]   <= 1'b1;
                                ent_tag[i] <= fail_addr;
                            end
                        end
                        used_cnt <= used_cnt + 3'd1;
                    end else if (is_new && full) begin
                        overflow <= 1'b1;
                        state    <= S_OVF;
                    end
                    // An overflow in the lock cycle wins; lock is dropped.
                    if (lock && !(is_new && full)) begin
                        state <= S_LOCK;
                    end
                end
                S_OVF: begin
                    if (lock) begin
                        state <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    state <= S_LOCK;
                end
                default: begin
                    state <= S_LOG;
                end
            endcase
        end
    end

`ifdef MBISR_HIT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            hit_cnt <= 8'd0;
        end else if (map_valid && map_spare && hit_cnt != 8'hFF) begin
            hit_cnt <= hit_cnt + 8'd1;
        end
    end
`else
    assign hit_cnt = 8'd0;
`endif

endmodule

// File: doc/mbisr_repair_map.md
Name: mbisr_repair_map

Overview:
- Repair side of the MBIST/MBISR pair. Consumes fail reports from the MBIST engine and allocates spare words to failing addresses.
- Once the engine signals done, the map is locked. Every functional access address is then translated to either the original array or a spare slot.
- Sits between the MBIST controller's fail-report interface and the memory address decode.

Parameters:
- ADDR_W, 4, memory address width in bits.
- SPARES, 2, number of spare words available (1..4).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous active-low reset.
- clr  input  1  synchronous clear of the map and status; used when MBIST restarts.
- fail_valid  input  1  MBIST presents a failing address this cycle.
- fail_addr  input  ADDR_W  failing address.
- fail_ready  output  1  map accepts the fail report this cycle.
- lock  input  1  one-cycle pulse from MBIST done; freezes the map.
- req_valid  input  1  functional lookup request.
- req_addr  input  ADDR_W  functional address to translate.
- map_valid  output  1  lookup result valid (registered).
- map_spare  output  1  1 = redirect to a spare slot, 0 = use the array.
- map_idx  output  2  spare slot index when map_spare=1, else 0.
- used_cnt  output  3  number of spares allocated.
- locked  output  1  map is frozen.
- overflow  output  1  more unique failures than SPARES (repair impossible).
- hit_cnt  output  8  remapped-lookup counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All entries invalid; state S_LOG.
  - fail_ready=1 combinationally from the state; map_valid=0, map_spare=0, map_idx=0.
  - used_cnt=0, locked=0, overflow=0, hit_cnt=0.
- clr=1 has the same effect as reset, one cycle. Priority: reset > clr > everything else.
- Entry storage: SPARES entries, each holding a valid bit and an ADDR_W-bit tag. Entries are allocated in ascending index order.
- States:
  - S_LOG: fail_ready=1. On fail_valid, fail_addr is compared with all valid tags.
    - Match: no change; duplicates are never re-allocated.
    - No match, used_cnt<SPARES: entry[used_cnt] <= {1,fail_addr}; used_cnt+1.
    - No match, used_cnt==SPARES: overflow<=1; go to S_OVF.
    - lock=1: go to S_LOCK. A fail report in the same cycle is still processed first.
    - If lock and overflow occur in the same cycle, the next state is S_OVF and overflow=1.
  - S_OVF: fail_ready=1; all fail reports are absorbed and ignored. overflow stays 1. lock moves to S_LOCK with overflow still 1.
  - S_LOCK: fail_ready=0; fail_valid is ignored. locked=1. The state is left only by clr or reset.
- Lookup: one-cycle registered latency, independent of state.
  - Cycle N: req_valid and req_addr are sampled.
  - Cycle N+1: map_valid=1. map_spare=1 and map_idx=lowest matching valid entry if req_addr hits, else map_spare=0 and map_idx=0.
  - map_valid=0 on any cycle following req_valid=0. Other outputs then hold their last values.
  - A lookup uses the map contents from before this edge; an allocation in the same cycle is not visible until the following lookup.
- Overflowed map: lookups still translate the allocated entries. The system treats overflow=1 as unrepairable.
- used_cnt saturates at SPARES.

Optional Feature:
- Macro: MBISR_HIT_CNT_EN.
- Defined: hit_cnt increments on every cycle where map_valid=1 and map_spare=1. It saturates at 255 and is cleared by reset or clr.
- Not defined: hit_cnt is tied to 0 and no counter flops are present.

Test Plan:
- Reset, then idle 5 cycles -> fail_ready=1, used_cnt=0, locked=0, overflow=0, map_valid=0.
- Fail 0x3, fail 0x9, fail 0x3 (duplicate), lock -> used_cnt=2, overflow=0, locked=1, fail_ready=0.
  - Lookup 0x9 -> next cycle map_valid=1, map_spare=1, map_idx=1.
  - Lookup 0x4 -> map_spare=0, map_idx=0.
- SPARES=2: fails 0x1, 0x2, 0x5 -> overflow=1 after the third.
  - A further fail 0x6 is absorbed (fail_ready=1) with used_cnt still 2.
  - Lock -> locked=1, overflow=1.
- Same cycle: fail 0x7 accepted and lookup 0x7 -> that lookup returns map_spare=0; a lookup of 0x7 on the next cycle returns map_spare=1, map_idx=0.
- After lock, assert clr -> all status returns to reset values; a new fail 0xA allocates entry 0.
- With MBISR_HIT_CNT_EN, map 0x3 and issue 300 consecutive lookups of 0x3 -> hit_cnt=255. Without the macro -> hit_cnt=0.
